// File: rtl/dcache_ctrl.sv
// Data-cache side memory-stage controller: checks alignment, issues one bus
// transaction per legal load/store and formats store lanes and load results.
module dcache_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        ren,
   input  logic [2:0]  rwidth,
   input  logic        rsign,
   input  logic        wen,
   input  logic [2:0]  wwidth,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        misalign,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic [2:0]  width_r;
   logic        sign_r;
   logic [1:0]  off_r;
   logic        req_s;
   logic [2:0]  width_s;
   logic        illegal_s;
   logic        accept_s;

   // Returns {wstrb, lane-replicated data} for a store of the given width.
   function automatic logic [35:0] fmt_store(input logic [2:0]  width,
                                             input logic [1:0]  off,
                                             input logic [31:0] data);
      logic [35:0] res;
      case (width)
         3'd1:    res = {4'b0001 << off, {4{data[7:0]}}};
         3'd2:    res = {(off[1] ? 4'b1100 : 4'b0011), {2{data[15:0]}}};
         3'd4:    res = {4'b1111, data};
         default: res = 36'd0;
      endcase
      return res;
   endfunction

   // Selects the addressed byte/halfword of a bus word and extends it.
   function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                            input logic [2:0]  width,
                                            input logic        sign,
                                            input logic [1:0]  off);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         2'd3:    b = word[31:24];
         default: b = 8'd0;
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (width)
         3'd1:    res = {{24{sign & b[7]}}, b};
         3'd2:    res = {{16{sign & h[15]}}, h};
         3'd4:    res = word;
         default: res = word;
      endcase
      return res;
   endfunction

   // Request legality; the width of whichever port is active is checked.
   always_comb begin
      req_s     = ren | wen;
      width_s   = wen ? wwidth : rwidth;
      illegal_s = 1'b0;
      if (ren & wen) begin
         illegal_s = 1'b1;
      end else begin
         case (width_s)
            3'd1:    illegal_s = 1'b0;
            3'd2:    illegal_s = addr[0];
            3'd4:    illegal_s = (addr[1:0] != 2'b00);
            default: illegal_s = 1'b1;
         endcase
      end
      accept_s = (state_r == IDLE) & req_s & ~illegal_s;
   end

   // Next-state logic and the combinational pipeline hold.
   always_comb begin
      state_s = state_r;
      stall   = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_s = BUSY;
            end else begin
               state_s = IDLE;
            end
            stall = accept_s & ~rst;
         end
         BUSY: begin
            if (bus_ack) begin
               state_s = DONE;
            end else begin
               state_s = BUSY;
            end
            stall = ~rst;
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register, bus transaction latches, load result and misalign pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= 32'd0;
         bus_wdata <= 32'd0;
         bus_wstrb <= 4'd0;
         rdata     <= 32'd0;
         misalign  <= 1'b0;
         width_r   <= 3'd0;
         sign_r    <= 1'b0;
         off_r     <= 2'd0;
      end else begin
         state_r  <= state_s;
         misalign <= (state_r == IDLE) & req_s & illegal_s;
         if (accept_s) begin
            bus_req  <= 1'b1;
            bus_we   <= wen;
            bus_addr <= {addr[31:2], 2'b00};
            width_r  <= width_s;
            sign_r   <= rsign;
            off_r    <= addr[1:0];
            if (wen) begin
               {bus_wstrb, bus_wdata} <= fmt_store(wwidth, addr[1:0], wdata);
            end else begin
               bus_wstrb <= 4'd0;
               bus_wdata <= 32'd0;
            end
         end else if ((state_r == BUSY) && bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) begin
               rdata <= fmt_load(bus_rdata, width_r, sign_r, off_r);
            end
         end
      end
   end

endmodule
